// File: rtl/reservoir_input_masker_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reservoir_input_masker_if : sample, mask-table and reservoir handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface reservoir_input_masker_if #(
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH        = 32
);
  localparam int c_aw = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1;

  logic                  sample_valid;
  logic [15:0]           sample_data;
  logic                  sample_ready;
  logic                  mask_wr_en;
  logic [c_aw-1:0]       mask_wr_addr;
  logic [7:0]            mask_wr_data;
  logic [DATA_WIDTH-1:0] res_din;
  logic                  res_en;
  logic                  res_valid;
  logic [c_aw-1:0]       node_idx;
  logic                  sample_done;
  logic                  timeout_err;

  modport slave (
    input  sample_valid, sample_data, mask_wr_en, mask_wr_addr, mask_wr_data, res_valid,
    output sample_ready, res_din, res_en, node_idx, sample_done, timeout_err
  );

  modport master (
    output sample_valid, sample_data, mask_wr_en, mask_wr_addr, mask_wr_data, res_valid,
    input  sample_ready, res_din, res_en, node_idx, sample_done, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/reservoir_input_masker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reservoir_input_masker : scales each sample by a per-node Q0.8 mask and feeds the reservoir
// Rev 1.0
// ----------------------------------------------------------------------------
module reservoir_input_masker #(
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  reservoir_input_masker_if.slave bus
);
  localparam int c_aw = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1;
  localparam int c_cw = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_aw-1:0] c_last_node = c_aw'(NUM_VIRTUAL_NODES - 1);
  localparam logic [c_cw-1:0] c_cnt_limit = c_cw'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MULT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_sample;
  logic [c_aw-1:0]       r_node;
  logic [c_cw-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_terr;
  logic [7:0]            w_mask [NUM_VIRTUAL_NODES];
  logic [7:0]            w_mask_sel;
  logic [23:0]           w_product;
  logic [15:0]           w_scaled;
  logic                  w_accept;
  logic                  w_node_ok;
  logic                  w_timeout;
  logic                  w_ready;
  logic                  w_en;
  logic                  w_done;

  for (genvar gi = 0; gi < NUM_VIRTUAL_NODES; gi++) begin : g_mask
    logic [7:0] r_entry;
    // Out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk) begin
      if (rst)
        r_entry <= '0;
      else if (bus.mask_wr_en && (bus.mask_wr_addr == c_aw'(gi)))
        r_entry <= bus.mask_wr_data;
    end
    assign w_mask[gi] = r_entry;
  end

  assign w_mask_sel = w_mask[r_node];
  assign w_product  = 24'(r_sample) * 24'(w_mask_sel);
  assign w_scaled   = 16'(w_product >> 8);

  // The first WAIT cycle (r_cnt == 0) ignores res_valid, covering reservoir response latency.
  assign w_accept  = (r_state == ST_IDLE) && bus.sample_valid;
  assign w_node_ok = (r_state == ST_WAIT) && (r_cnt != '0) && bus.res_valid;
  assign w_timeout = (r_state == ST_WAIT) && !w_node_ok && (r_cnt == c_cnt_limit);

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_en        = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.sample_valid) w_state_nxt = ST_MULT;
      end
      ST_MULT:  w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        w_en        = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_node_ok)
          w_state_nxt = (r_node == c_last_node) ? ST_DONE : ST_MULT;
        else if (w_timeout)
          w_state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample <= '0;
      r_node   <= '0;
      r_cnt    <= '0;
      r_din    <= '0;
      r_terr   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sample <= bus.sample_data;
        r_node   <= '0;
        r_terr   <= 1'b0;
      end
      if (r_state == ST_MULT)
        r_din <= DATA_WIDTH'(w_scaled);
      if (r_state == ST_ISSUE)
        r_cnt <= '0;
      else if (r_state == ST_WAIT)
        r_cnt <= r_cnt + 1'b1;
      if (w_node_ok && (r_node != c_last_node))
        r_node <= r_node + 1'b1;
      if (w_timeout) begin
        r_terr <= 1'b1;
        r_node <= '0;
      end
      if (r_state == ST_DONE)
        r_node <= '0;
    end
  end

  assign bus.sample_ready = w_ready;
  assign bus.res_en       = w_en;
  assign bus.sample_done  = w_done;
  assign bus.res_din      = r_din;
  assign bus.node_idx     = r_node;
  assign bus.timeout_err  = r_terr;
endmodule
`default_nettype wire

// File: tb/tb_reservoir_input_masker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reservoir_input_masker : directed + randomized bench with a reservoir responder
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_reservoir_input_masker;
  localparam int N  = 10;
  localparam int DW = 32;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mref [N];
  logic rsp_hold = 1'b0;
  logic prev_ready = 1'b0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] din;
    logic [3:0]    idx;
  } en_t;
  en_t en_q[$];
  int  acc_q[$];
  int  done_q[$];

  reservoir_input_masker_if #(.NUM_VIRTUAL_NODES(N), .DATA_WIDTH(DW)) bus ();

  reservoir_input_masker #(
    .NUM_VIRTUAL_NODES(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle; cyc here is the index of the edge just taken.
  always @(negedge clk) begin
    en_t e;
    if (prev_ready && bus.sample_valid && !rst) acc_q.push_back(cyc);
    if (bus.res_en) begin
      e.cyc = cyc;
      e.din = bus.res_din;
      e.idx = bus.node_idx;
      en_q.push_back(e);
    end
    if (bus.sample_done) done_q.push_back(cyc);
    prev_ready = bus.sample_ready;
  end

  // Reservoir: after each en, res_valid low for the next 4 edges, then high again.
  initial begin
    int lo;
    lo = 0;
    bus.res_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.res_en) begin
        bus.res_valid = 1'b0;
        lo = 5;
      end else if (rsp_hold) begin
        bus.res_valid = 1'b0;
      end else if (lo > 0) begin
        lo--;
        if (lo == 0) bus.res_valid = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready"}, bus.sample_ready, 1);
    check({tag, "_en"}, bus.res_en, 0);
    check({tag, "_din"}, bus.res_din, 0);
    check({tag, "_idx"}, bus.node_idx, 0);
    check({tag, "_done"}, bus.sample_done, 0);
    check({tag, "_terr"}, bus.timeout_err, 0);
  endtask

  task automatic write_mask(input logic [3:0] a, input logic [7:0] v);
    bus.mask_wr_en   = 1'b1;
    bus.mask_wr_addr = a;
    bus.mask_wr_data = v;
    tick();
    bus.mask_wr_en = 1'b0;
    if (a < N) mref[a] = v;
  endtask

  task automatic start_sample(input logic [15:0] d, input bit hold, output int t);
    int base, k;
    base = acc_q.size();
    k = 0;
    bus.sample_data  = d;
    bus.sample_valid = 1'b1;
    while (acc_q.size() == base && k < 200) begin
      tick();
      k++;
    end
    check("accept_seen", acc_q.size() > base, 1);
    t = (acc_q.size() > base) ? acc_q[base] : cyc;
    if (!hold) bus.sample_valid = 1'b0;
  endtask

  task automatic wait_end(input int db, output int tc);
    int k;
    k = 0;
    while (!(done_q.size() > db || bus.timeout_err === 1'b1) && k < 800) begin
      tick();
      k++;
    end
    tc = cyc;
    check("end_seen", (done_q.size() > db) || (bus.timeout_err === 1'b1), 1);
  endtask

  task automatic wait_pulses(input int target);
    int k;
    k = 0;
    while (en_q.size() < target && k < 400) begin
      tick();
      k++;
    end
    check("pulses_reached", en_q.size() >= target, 1);
  endtask

  // Expected node value: (sample * mask) >> 8, pulses every 7 cycles from T+1, done at T+7N.
  task automatic check_sample(input int t, input logic [15:0] d, input int eb, input int db);
    int dc, n;
    logic [DW-1:0] exp;
    dc = (done_q.size() > db) ? done_q[db] : t + 100000;
    n = 0;
    for (int i = eb; i < en_q.size(); i++) if (en_q[i].cyc <= dc) n++;
    check("pulse_count", n, N);
    for (int i = 0; i < n && i < N; i++) begin
      exp = DW'((32'(d) * 32'(mref[i])) >> 8);
      check("node_din", en_q[eb+i].din, exp);
      check("node_idx", en_q[eb+i].idx, i);
      check("node_issue_cyc", en_q[eb+i].cyc - t, 1 + 7 * i);
    end
    check("done_cyc", dc - t, 7 * N);
    tick();
    check("ready_after_done", bus.sample_ready, 1);
  endtask

  initial begin
    int t, t2, tc, eb, db, ab, c3, n0;
    logic [15:0] d;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.mask_wr_en   = 1'b0;
    bus.mask_wr_addr = '0;
    bus.mask_wr_data = '0;
    for (int i = 0; i < N; i++) mref[i] = 8'd0;

    rst = 1'b1;
    tick();
    reset_checks("rst0");
    tick();
    rst = 1'b0;
    tick();

    // Unity-ish gain on every node.
    for (int i = 0; i < N; i++) write_mask(4'(i), 8'd255);
    eb = en_q.size(); db = done_q.size();
    start_sample(16'h8000, 0, t);
    wait_end(db, tc);
    check("unity_din0", en_q.size() > eb ? en_q[eb].din : 'x, 32'h0000_7F80);
    check_sample(t, 16'h8000, eb, db);

    // Ramp of masks.
    for (int i = 0; i < N; i++) write_mask(4'(i), 8'(16 * i));
    eb = en_q.size(); db = done_q.size();
    start_sample(16'hFFFF, 0, t);
    wait_end(db, tc);
    check("ramp_node0_zero", en_q.size() > eb ? en_q[eb].din : 'x, 0);
    check_sample(t, 16'hFFFF, eb, db);

    // Valid held through a whole sample: one capture, next accepted right after DONE.
    eb = en_q.size(); db = done_q.size(); ab = acc_q.size();
    start_sample(16'h1234, 1, t);
    bus.sample_data = 16'hBEEF;
    wait_end(db, tc);
    check("held_one_capture", acc_q.size() - ab, 1);
    check_sample(t, 16'h1234, eb, db);
    tick();
    check("held_second_accept", acc_q.size() > ab + 1, 1);
    t2 = (acc_q.size() > ab + 1) ? acc_q[ab+1] : 0;
    check("held_second_accept_cyc", t2 - ((done_q.size() > db) ? done_q[db] : 0), 2);
    bus.sample_valid = 1'b0;
    wait_end(db + 1, tc);
    check_sample(t2, 16'hBEEF, eb + N, db + 1);

    // Mask rewrite during node 2's WAIT, then an out-of-range write.
    for (int i = 0; i < N; i++) write_mask(4'(i), 8'($urandom_range(0, 255)));
    eb = en_q.size(); db = done_q.size();
    d = 16'($urandom);
    start_sample(d, 0, t);
    wait_pulses(eb + 3);
    tick();
    write_mask(4'd5, ~mref[5]);
    wait_end(db, tc);
    check_sample(t, d, eb, db);
    write_mask(4'd12, 8'hAA);
    eb = en_q.size(); db = done_q.size();
    d = 16'($urandom);
    start_sample(d, 0, t);
    wait_end(db, tc);
    check_sample(t, d, eb, db);

    // Randomized masks (including stray addresses) and samples.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) write_mask(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      eb = en_q.size(); db = done_q.size();
      d = 16'($urandom);
      start_sample(d, 0, t);
      wait_end(db, tc);
      check_sample(t, d, eb, db);
    end

    // Reservoir goes silent after the 3rd issue.
    eb = en_q.size(); db = done_q.size();
    start_sample(16'h4321, 0, t);
    wait_pulses(eb + 3);
    rsp_hold = 1'b1;
    c3 = (en_q.size() > eb + 2) ? en_q[eb+2].cyc : cyc;
    wait_end(db, tc);
    check("to_err", bus.timeout_err, 1);
    check("to_no_done", done_q.size() - db, 0);
    check("to_pulses", en_q.size() - eb, 3);
    check("to_ready", bus.sample_ready, 1);
    check("to_idx", bus.node_idx, 0);
    check("to_latency_window", (tc - c3 >= TO) && (tc - c3 <= TO + 2), 1);
    repeat (3) tick();
    check("to_sticky", bus.timeout_err, 1);
    rsp_hold = 1'b0;
    repeat (8) tick();
    eb = en_q.size(); db = done_q.size();
    d = 16'($urandom);
    start_sample(d, 0, t);
    check("to_cleared_on_accept", bus.timeout_err, 0);
    wait_end(db, tc);
    check_sample(t, d, eb, db);

    // Reset during node 4's WAIT.
    eb = en_q.size(); db = done_q.size();
    start_sample(16'hFFFF, 0, t);
    wait_pulses(eb + 5);
    tick();
    tick();
    rst = 1'b1;
    tick();
    reset_checks("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < N; i++) mref[i] = 8'd0;
    n0 = en_q.size();
    repeat (20) tick();
    check("rst_no_en", en_q.size() - n0, 0);
    check("rst_no_done", done_q.size() - db, 0);
    eb = en_q.size(); db = done_q.size();
    start_sample(16'hFFFF, 0, t);
    wait_end(db, tc);
    check_sample(t, 16'hFFFF, eb, db);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
